// File: rtl/cube_mm_seq.sv
// Job sequencer for the NxNxN MAC cube. It feeds K operand tile pairs to the
// cube one at a time and holds each pair until the cube result has settled. It
// sums the per-tile NxN results into a wide accumulator bank and then returns
// the final block on a valid/ready output.
module cube_mm_seq #(
    parameter int unsigned N         = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + $clog2(N),
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned KW        = 8,
    parameter int unsigned CUBE_LAT  = 3 * N
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [KW-1:0]                cmd_ktiles,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*N*WIDTH-1:0]         in_a,
    input  logic [N*N*WIDTH-1:0]         in_b,
    output logic [N*N*WIDTH-1:0]         cube_a,
    output logic [N*N*WIDTH-1:0]         cube_b,
    input  logic [N*N*ACC_WIDTH-1:0]     cube_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*N*OUT_WIDTH-1:0]     out_data,
    output logic                         busy
);

    localparam int unsigned HCW = (CUBE_LAT > 1) ? $clog2(CUBE_LAT) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(CUBE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StHold, StOut} state_e;

    state_e                      state_q, state_d;
    logic [KW-1:0]               ktiles_q, ktiles_d;
    logic [KW-1:0]               k_cnt_q, k_cnt_d;
    logic [HCW-1:0]              hold_cnt_q, hold_cnt_d;
    logic [N*N*WIDTH-1:0]        cube_a_q, cube_a_d;
    logic [N*N*WIDTH-1:0]        cube_b_q, cube_b_d;
    logic [N*N*OUT_WIDTH-1:0]    acc_q, acc_d;

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ktiles_q   <= '0;
            k_cnt_q    <= '0;
            hold_cnt_q <= '0;
            cube_a_q   <= '0;
            cube_b_q   <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            ktiles_q   <= ktiles_d;
            k_cnt_q    <= k_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            cube_a_q   <= cube_a_d;
            cube_b_q   <= cube_b_d;
            acc_q      <= acc_d;
        end
    end

    // Next-state logic: job accept, operand load, settle/accumulate, deliver.
    always_comb begin
        state_d    = state_q;
        ktiles_d   = ktiles_q;
        k_cnt_d    = k_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cube_a_d   = cube_a_q;
        cube_b_d   = cube_b_q;
        acc_d      = acc_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    ktiles_d = cmd_ktiles;
                    k_cnt_d  = '0;
                    if (cmd_ktiles == '0) begin
                        acc_d   = '0;
                        state_d = StOut;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    cube_a_d   = in_a;
                    cube_b_d   = in_b;
                    hold_cnt_d = '0;
                    state_d    = StHold;
                end
            end
            StHold: begin
                hold_cnt_d = hold_cnt_q + HCW'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    // First tile of a job overwrites whatever the previous job left behind.
                    for (int unsigned e = 0; e < N * N; e++) begin
                        acc_d[e*OUT_WIDTH +: OUT_WIDTH] =
                            ((k_cnt_q == '0) ? '0 : acc_q[e*OUT_WIDTH +: OUT_WIDTH])
                            + OUT_WIDTH'($signed(cube_result[e*ACC_WIDTH +: ACC_WIDTH]));
                    end
                    if (k_cnt_q == ktiles_q - KW'(1)) begin
                        state_d = StOut;
                    end else begin
                        k_cnt_d = k_cnt_q + KW'(1);
                        state_d = StLoad;
                    end
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign cube_a    = cube_a_q;
    assign cube_b    = cube_b_q;
    assign out_data  = acc_q;

endmodule

// File: doc/cube_mm_seq.md
# cube_mm_seq

Sequencer for the N×N×N MAC cube array. It accepts a matmul job of K operand tile pairs and presents each pair to the cube long enough for the systolic skew and the y-reduction chain to settle. It samples and accumulates the cube's N×N partial result per tile into a wider accumulator bank, then returns the final N×N block through a valid/ready output. It sits between the operand fetch/DMA front end and the cube instance.

## Interface
- N, 8, cube dimension
- WIDTH, 8, operand element width (signed)
- ACC_WIDTH, 2*WIDTH+$clog2(N), cube result element width (signed)
- OUT_WIDTH, 32, accumulator/output element width (signed, ≥ ACC_WIDTH)
- KW, 8, width of tile count
- CUBE_LAT, 3*N, cycles operands are held before cube_result is sampled

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE
- cmd_ktiles  in  KW  number of tile pairs in the job (0 legal)
- in_valid  in  1  operand pair valid
- in_ready  out  1  high only in LOAD
- in_a  in  N*N*WIDTH  A tile, same packing as cube A
- in_b  in  N*N*WIDTH  B tile, same packing as cube B
- cube_a  out  N*N*WIDTH  registered A to cube
- cube_b  out  N*N*WIDTH  registered B to cube
- cube_result  in  N*N*ACC_WIDTH  cube output; element (z,x) at [(z*N+x)*ACC_WIDTH +: ACC_WIDTH]
- out_valid  out  1  result block valid
- out_ready  in  1  consumer accept
- out_data  out  N*N*OUT_WIDTH  accumulated block; element (z,x) at [(z*N+x)*OUT_WIDTH +: OUT_WIDTH]
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, LOAD, HOLD, OUT.
- IDLE: cmd_ready=1. On cmd_valid, latch ktiles and clear k_cnt. If ktiles==0, clear acc and go to OUT; otherwise go to LOAD.
- LOAD: in_ready=1. On in_valid, register in_a/in_b into cube_a/cube_b, clear hold_cnt, and go to HOLD. Stall indefinitely without in_valid.
- HOLD: cube_a/cube_b stay constant. hold_cnt increments each cycle. In the cycle with hold_cnt==CUBE_LAT-1, each element is updated as acc = (k_cnt==0 ? 0 : acc) + sext(cube_result elem).
  - Same edge, if k_cnt==ktiles-1, go to OUT.
  - Otherwise k_cnt++ and go to LOAD.
- OUT: out_valid=1 and out_data=acc, both stable until out_ready. On out_valid&out_ready, go to IDLE. acc is retained until the next job's first sample.
- Arithmetic: signed two's complement. ACC_WIDTH results are sign-extended to OUT_WIDTH. Accumulation wraps modulo 2^OUT_WIDTH, with no saturation.
- cube_a/cube_b change only on an accepted in beat. They hold their values through OUT/IDLE.
- A new cmd is not accepted until the current block is delivered. There is no overlap of jobs.

## Timing
- Reset values: state=IDLE, cmd_ready=1, in_ready=0, out_valid=0, busy=0, cube_a=0, cube_b=0, out_data=0, all counters 0.
- Reset mid-job: the job is abandoned immediately, with no output produced. After release the block is in IDLE.
- Each tile costs 1 LOAD cycle (with in_valid already high) plus CUBE_LAT HOLD cycles.
- With continuous in_valid, out_valid rises K*(CUBE_LAT+1)+1 cycles after the cmd accept edge (1 cycle for IDLE→LOAD).
- ktiles==0: out_valid rises 1 cycle after cmd accept, with out_data=0.
- ktiles==2^KW-1: k_cnt compares without overflow.
- out_ready held low: out_valid and out_data stay stable, and cmd_ready stays 0.
- cmd_valid while busy is ignored (cmd_ready=0). in_valid outside LOAD is ignored (in_ready=0).

## Test plan
- N=2, WIDTH=8, K=1, A=all 1, B=all 2. Bench cube model returns the dot product after CUBE_LAT cycles. Required: out_data each element = 4; out_valid at cycle CUBE_LAT+2 after cmd; cube_a stable throughout HOLD.
- K=3, each tile gives result elements of 127, −128, 5, 0. Required: out_data = 381, −384, 15, 0; exactly one out beat; in_ready high exactly 3 times.
- K=0. Required: out_valid 1 cycle after cmd, all out_data zero, no in_ready pulse.
- Backpressure: hold out_ready=0 for 10 cycles with cmd_valid=1 asserted. Required: out_data stable, cmd_ready=0, second job starts only after the out handshake; second job's acc does not include first job's sum.
- in_valid gaps of 5 cycles between tiles (K=2). Required: correct sum and HOLD not entered until accept. OUT_WIDTH=ACC_WIDTH with max-positive results for K=2 → wrapped two's-complement value.
- Assert rst_n during HOLD of tile 2. Required: outputs return to their reset values asynchronously. The next job with K=1 returns only its own tile's result.
